packet_reassembly: RTL and testbench

PACKET_REASSEMBLY -- requirements
Module: packet_reassembly

---
 rtl/stream_manager_pkg.sv | 18 +
 rtl/packet_reassembly_if.sv | 17 +
 rtl/axis_skid_buffer.sv | 76 +++++++
 rtl/packet_reassembly.sv | 145 ++++++++++++++
 tb/tb_packet_reassembly.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_manager_pkg.sv
// Shared types for the packet reassembly block: FSM state encoding, widths, helpers.
package stream_manager_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/packet_reassembly_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast/tuser) with master/slave views.
interface packet_reassembly_if
  import stream_manager_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: full throughput with a flop-driven s-side ready.
module axis_skid_buffer #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  input  logic              i_s_user,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last,
  output logic              o_m_user,
  output logic              o_m_valid,
  input  logic              i_m_ready
);

  localparam int unsigned PW = DATA_W + 2;

  logic [PW-1:0] r_out, r_skid, w_out_n, w_skid_n, w_in;
  logic          r_out_valid, r_skid_valid, r_s_ready;
  logic          w_out_valid_n, w_skid_valid_n, w_push, w_pop;

  assign w_in   = {i_s_user, i_s_last, i_s_data};
  assign w_push = i_s_valid & r_s_ready;
  assign w_pop  = r_out_valid & i_m_ready;

  // Skid entry only fills when the output entry is stalled; it drains first.
  always_comb begin
    w_out_n        = r_out;
    w_out_valid_n  = r_out_valid;
    w_skid_n       = r_skid;
    w_skid_valid_n = r_skid_valid;
    if (r_skid_valid) begin
      if (w_pop) begin
        w_out_n        = r_skid;
        w_out_valid_n  = 1'b1;
        w_skid_valid_n = 1'b0;
      end
    end else if (w_push) begin
      if (!r_out_valid || w_pop) begin
        w_out_n       = w_in;
        w_out_valid_n = 1'b1;
      end else begin
        w_skid_n       = w_in;
        w_skid_valid_n = 1'b1;
      end
    end else if (w_pop) begin
      w_out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      r_out        <= w_out_n;
      r_skid       <= w_skid_n;
      r_out_valid  <= w_out_valid_n;
      r_skid_valid <= w_skid_valid_n;
      r_s_ready    <= ~w_skid_valid_n;
    end
  end

  assign o_s_ready = r_s_ready;
  assign o_m_data  = r_out[DATA_W-1:0];
  assign o_m_last  = r_out[DATA_W];
  assign o_m_user  = r_out[DATA_W+1];
  assign o_m_valid = r_out_valid;

endmodule

// File: rtl/packet_reassembly.sv
// Reassembles mss-sized fragments into one transfer_size-beat stream, flagging length errors.
// Optional statistics counters are built when PACKET_REASSEMBLY_STATS_EN is defined.
module packet_reassembly
  import stream_manager_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 arst,
  packet_reassembly_if.slave   s_axis,
  packet_reassembly_if.master  m_axis,
  input  logic                 trigger,
  input  logic [CNT_W-1:0]     mss,
  input  logic [CNT_W-1:0]     transfer_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err_short,
  output logic                 err_long,
  output logic [CNT_W-1:0]     frag_count,
  output logic [CNT_W-1:0]     err_count
);

  state_t           r_state, w_state_n;
  logic             r_trig_d;
  logic [CNT_W-1:0] r_mss, r_ts, r_total, r_in_frag;
  logic             r_err_short, r_err_long, r_user_seen, r_busy, r_done;
  logic             w_recv, w_arm, w_m_fin, w_skid_ready, w_acc, w_final;
  logic             w_short, w_long, w_boundary, w_user_any;
  logic [CNT_W-1:0] w_remain, w_exp, w_cnt;

  always_ff @(posedge clk) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_arm)            w_state_n = RECV;
      RECV:    if (w_acc && w_final) w_state_n = DRAIN;
      DRAIN:   if (w_m_fin)          w_state_n = IDLE;
      default:                       w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_recv  = 1'b0;
    w_arm   = 1'b0;
    w_m_fin = 1'b0;
    case (r_state)
      IDLE:    w_arm   = trigger & ~r_trig_d & (mss != '0) & (transfer_size != '0);
      RECV:    w_recv  = 1'b1;
      DRAIN:   w_m_fin = m_axis.tvalid & m_axis.tready & m_axis.tlast;
      default: ;
    endcase
  end

  assign s_axis.tready = w_recv & w_skid_ready;
  assign w_acc         = s_axis.tvalid & s_axis.tready;

  // Expected length is mss, clipped to what remains of the transfer from this fragment's start.
  assign w_cnt      = r_in_frag + 32'd1;
  assign w_remain   = r_ts - (r_total - r_in_frag);
  assign w_exp      = min_cnt(r_mss, w_remain);
  assign w_final    = (r_total + 32'd1) == r_ts;
  assign w_short    = s_axis.tlast & (w_cnt < w_exp);
  assign w_long     = ~s_axis.tlast & (w_cnt == w_exp);
  assign w_boundary = s_axis.tlast | (w_cnt == w_exp);
  assign w_user_any = r_err_short | r_err_long | r_user_seen | w_short | w_long | s_axis.tuser;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_trig_d    <= trigger;
      r_mss       <= '0;
      r_ts        <= '0;
      r_total     <= '0;
      r_in_frag   <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_user_seen <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_trig_d <= trigger;
      r_busy   <= (w_state_n != IDLE);
      r_done   <= w_m_fin;
      if (w_arm) begin
        r_mss       <= mss;
        r_ts        <= transfer_size;
        r_total     <= '0;
        r_in_frag   <= '0;
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
        r_user_seen <= 1'b0;
      end else if (w_acc) begin
        r_total   <= r_total + 32'd1;
        r_in_frag <= w_boundary ? '0 : w_cnt;
        if (w_short)      r_err_short <= 1'b1;
        if (w_long)       r_err_long  <= 1'b1;
        if (s_axis.tuser) r_user_seen <= 1'b1;
      end
    end
  end

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .arst      (arst),
    .i_s_data  (s_axis.tdata),
    .i_s_last  (w_final),
    .i_s_user  (w_final & w_user_any),
    .i_s_valid (s_axis.tvalid & w_recv),
    .o_s_ready (w_skid_ready),
    .o_m_data  (m_axis.tdata),
    .o_m_last  (m_axis.tlast),
    .o_m_user  (m_axis.tuser),
    .o_m_valid (m_axis.tvalid),
    .i_m_ready (m_axis.tready)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;

`ifdef PACKET_REASSEMBLY_STATS_EN
  logic [CNT_W-1:0] r_frag_cnt, r_err_cnt;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_frag_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_acc) begin
      if (w_boundary)       r_frag_cnt <= r_frag_cnt + 32'd1;
      if (w_short | w_long) r_err_cnt  <= r_err_cnt + 32'd1;
    end
  end

  assign frag_count = r_frag_cnt;
  assign err_count  = r_err_cnt;
`else
  assign frag_count = '0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_packet_reassembly.sv
// Randomized bench for packet_reassembly against a fragment-level reference model.
module tb_packet_reassembly;

  localparam int unsigned DW = 64;
`ifdef PACKET_REASSEMBLY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        trigger = 1'b0;
  logic [31:0] mss = '0;
  logic [31:0] transfer_size = '0;
  logic        busy, done, err_short, err_long;
  logic [31:0] frag_count, err_count;

  packet_reassembly_if #(.DATA_W(DW)) s_if ();
  packet_reassembly_if #(.DATA_W(DW)) m_if ();

  always #5 clk = ~clk;

  packet_reassembly #(.DATA_W(DW)) dut (
    .clk           (clk),
    .arst          (arst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .trigger       (trigger),
    .mss           (mss),
    .transfer_size (transfer_size),
    .busy          (busy),
    .done          (done),
    .err_short     (err_short),
    .err_long      (err_long),
    .frag_count    (frag_count),
    .err_count     (err_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] b_data[$];
  bit          b_last[$];
  bit          b_user[$];
  logic [63:0] o_data[$];
  bit          o_last[$];
  bit          o_user[$];
  int          exp_frag = 0;
  int          exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_s_tready"}, 64'(s_if.tready), 64'd0);
    chk({pfx, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
    chk({pfx, "_m_tlast"}, 64'(m_if.tlast), 64'd0);
    chk({pfx, "_m_tuser"}, 64'(m_if.tuser), 64'd0);
    chk({pfx, "_m_tdata"}, m_if.tdata, 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_err_short"}, 64'(err_short), 64'd0);
    chk({pfx, "_err_long"}, 64'(err_long), 64'd0);
    chk({pfx, "_frag_count"}, 64'(frag_count), 64'd0);
    chk({pfx, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  task automatic fill(input int ts, input int m, input bit rnd);
    b_data.delete(); b_last.delete(); b_user.delete();
    for (int i = 0; i < ts; i++) begin
      b_data.push_back({$urandom(), $urandom()});
      if (rnd) begin
        b_last.push_back(($urandom_range(4) == 0) || (i == ts - 1));
        b_user.push_back($urandom_range(15) == 0);
      end else begin
        b_last.push_back((((i + 1) % m) == 0) || (i == ts - 1));
        b_user.push_back(1'b0);
      end
    end
  endtask

  // Drives one transfer, collects output beats, then compares with the fragment model.
  task automatic run_xfer(input int m, input int ts, input bit rnd, input int abort_after,
                          input bit retrig);
    int idx = 0, cyc = 0, occ = 0, done_n = 0, post = 0;
    int start = 0, pos = 0, frags = 0, errs = 0, e;
    bit es = 0, el = 0, usr = 0, s_hs, m_hs;
    o_data.delete(); o_last.delete(); o_user.delete();
    for (int i = 0; i < ts; i++) begin
      pos++;
      e = (m < ts - start) ? m : ts - start;
      usr |= b_user[i];
      if (b_last[i] && pos < e) begin
        es = 1; errs++; frags++; start = i + 1; pos = 0;
      end else if (pos == e) begin
        if (!b_last[i]) begin el = 1; errs++; end
        frags++; start = i + 1; pos = 0;
      end
    end
    @(negedge clk);
    mss = 32'(m); transfer_size = 32'(ts); trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    while (cyc < 2000) begin
      if (retrig && cyc == 6) begin
        trigger = 1'b1; mss = 32'(m + 3); transfer_size = 32'(ts + 5);
      end
      if (retrig && cyc == 7) trigger = 1'b0;
      s_if.tvalid = (idx < ts) && (!rnd || $urandom_range(3) != 0);
      s_if.tdata  = (idx < ts) ? b_data[idx] : 64'd0;
      s_if.tlast  = (idx < ts) ? b_last[idx] : 1'b0;
      s_if.tuser  = (idx < ts) ? b_user[idx] : 1'b0;
      m_if.tready = !rnd || ($urandom_range(1) == 1);
      #1;
      if (s_if.tready) chk("s_ready_while_full", 64'(occ < 2), 64'd1);
      if (done) done_n++;
      s_hs = s_if.tvalid && s_if.tready;
      m_hs = m_if.tvalid && m_if.tready;
      if (s_hs) begin idx++; occ++; end
      if (m_hs) begin
        o_data.push_back(m_if.tdata); o_last.push_back(m_if.tlast); o_user.push_back(m_if.tuser);
        occ--;
      end
      if (abort_after != 0 && idx == abort_after) break;
      if (done_n > 0 && idx == ts) post++;
      if (post > 3) break;
      @(negedge clk);
      cyc++;
    end
    if (abort_after != 0) return;
    s_if.tvalid = 1'b0;
    chk("xfer_completes", 64'(post > 3), 64'd1);
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("beats_out", 64'(o_data.size()), 64'(ts));
    for (int i = 0; i < o_data.size() && i < ts; i++) begin
      chk("beat_data", o_data[i], b_data[i]);
      chk("beat_last", 64'(o_last[i]), 64'(i == ts - 1));
      chk("beat_user", 64'(o_user[i]), 64'((i == ts - 1) && (es || el || usr)));
    end
    exp_frag += frags;
    exp_err  += errs;
    chk("busy_after", 64'(busy), 64'd0);
    chk("err_short", 64'(err_short), 64'(es));
    chk("err_long", 64'(err_long), 64'(el));
    chk("frag_count", 64'(frag_count), STATS ? 64'(exp_frag) : 64'd0);
    chk("err_count", 64'(err_count), STATS ? 64'(exp_err) : 64'd0);
  endtask

  task automatic bad_arm(input int m, input int ts);
    @(negedge clk);
    mss = 32'(m); transfer_size = 32'(ts); trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("bad_arm_busy", 64'(busy), 64'd0);
    chk("bad_arm_s_tready", 64'(s_if.tready), 64'd0);
    chk("bad_arm_frag_count", 64'(frag_count), STATS ? 64'(exp_frag) : 64'd0);
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    arst = 1'b0;

    fill(10, 4, 1'b0);
    run_xfer(4, 10, 1'b0, 0, 1'b0);
    run_xfer(4, 10, 1'b1, 0, 1'b0);

    b_data.delete(); b_last.delete(); b_user.delete();
    for (int i = 0; i < 8; i++) begin
      b_data.push_back({$urandom(), $urandom()});
      b_last.push_back(i == 2 || i == 7);
      b_user.push_back(1'b0);
    end
    run_xfer(4, 8, 1'b0, 0, 1'b0);

    bad_arm(0, 5);
    bad_arm(3, 0);

    fill(12, 5, 1'b0);
    run_xfer(5, 12, 1'b1, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int m_r, ts_r;
      m_r  = int'($urandom_range(6, 1));
      ts_r = int'($urandom_range(20, 1));
      fill(ts_r, m_r, 1'b1);
      run_xfer(m_r, ts_r, 1'b1, 0, 1'b0);
    end

    fill(10, 4, 1'b0);
    run_xfer(4, 10, 1'b0, 5, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    #1;
    check_zero("mid_reset");
    arst = 1'b0;
    exp_frag = 0;
    exp_err  = 0;
    fill(4, 4, 1'b0);
    run_xfer(4, 4, 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
